// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready load, per-bit clock divider,
// selectable bit order and optional start/stop framing around each word.
module piso_serializer #(
  parameter int       WIDTH     = 32,
  parameter int       CLK_DIV   = 1,
  parameter bit       MSB_FIRST = 1'b0,
  parameter logic     IDLE_VAL  = 1'b1,
  parameter int       START_BIT = 0,
  parameter int       STOP_BITS = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             so,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state_o
);

  localparam int N  = START_BIT + WIDTH + STOP_BITS;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // Handshake: a word transfers on any rising clk edge where in_valid and
  // in_ready are both 1; in_ready depends only on state and counters.
  state_e         state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [N-1:0]   sh_q, sh_d;
  logic           so_q, so_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [N-1:0]   frame_w;
  logic           active_w;
  logic           bit_end_w;
  logic           last_bit_w;
  logic           frame_end_w;
  logic           hs_w;

  function automatic state_e state_for(input int idx);
    if (START_BIT != 0 && idx == 0)  return S_START;
    else if (idx < START_BIT + WIDTH) return S_DATA;
    else                              return S_STOP;
  endfunction

  // The whole frame is laid out LSB-first so one right shift serves every bit.
  always_comb begin
    frame_w = '0;
    if (START_BIT != 0) frame_w[0] = ~IDLE_VAL;
    for (int i = 0; i < WIDTH; i++) begin
      frame_w[START_BIT + i] = MSB_FIRST ? in_data[WIDTH-1-i] : in_data[i];
    end
    for (int j = 0; j < STOP_BITS; j++) begin
      frame_w[START_BIT + WIDTH + j] = IDLE_VAL;
    end
  end

  always_comb begin
    active_w    = (state_q != S_IDLE);
    bit_end_w   = (div_q == DW'(CLK_DIV - 1));
    last_bit_w  = (bit_q == BW'(N - 1));
    frame_end_w = active_w && bit_end_w && last_bit_w;
    in_ready    = !active_w || frame_end_w;
    hs_w        = in_valid && in_ready;

    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    so_d    = so_q;
    busy_d  = busy_q;
    done_d  = frame_end_w;

    if (hs_w) begin
      state_d = state_for(0);
      div_d   = '0;
      bit_d   = '0;
      sh_d    = frame_w;
      so_d    = frame_w[0];
      busy_d  = 1'b1;
    end else if (frame_end_w) begin
      state_d = S_IDLE;
      div_d   = '0;
      bit_d   = '0;
      so_d    = IDLE_VAL;
      busy_d  = 1'b0;
    end else if (active_w && bit_end_w) begin
      state_d = state_for(int'(bit_q) + 1);
      div_d   = '0;
      bit_d   = bit_q + 1'b1;
      so_d    = sh_q[1];
      sh_d    = sh_q >> 1;
    end else if (active_w) begin
      div_d   = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      so_q    <= IDLE_VAL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      so_q    <= so_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign so          = so_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three configurations (LSB-first, MSB-first,
// framed with divider) checked bit by bit against hand-written frame patterns.
module tb_piso_serializer;

  logic       clk;
  logic       rst_n;
  logic [2:0] valid_w;
  logic [7:0] data_w;
  logic [2:0] ready_w, so_w, busy_w, done_w;
  logic [1:0] st0_w, st1_w, st2_w;

  int errors = 0;
  int checks = 0;

  piso_serializer #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1'b0), .IDLE_VAL(1'b1),
                    .START_BIT(0), .STOP_BITS(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_w[0]), .in_ready(ready_w[0]),
    .in_data(data_w), .so(so_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .dbg_state_o(st0_w));

  piso_serializer #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1'b1), .IDLE_VAL(1'b1),
                    .START_BIT(0), .STOP_BITS(0)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_w[1]), .in_ready(ready_w[1]),
    .in_data(data_w), .so(so_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .dbg_state_o(st1_w));

  piso_serializer #(.WIDTH(8), .CLK_DIV(4), .MSB_FIRST(1'b0), .IDLE_VAL(1'b1),
                    .START_BIT(1), .STOP_BITS(1)) u_frm (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_w[2]), .in_ready(ready_w[2]),
    .in_data(data_w), .so(so_w[2]), .busy(busy_w[2]), .done(done_w[2]),
    .dbg_state_o(st2_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // seq[b] is the expected level of serial bit b; n bits of div cycles each.
  task automatic run_frame(input int u, input logic [15:0] seq, input int n,
                           input int div, input logic [7:0] data, input bit inject);
    int cyc;
    data_w     = data;
    valid_w[u] = 1'b1;
    step();
    valid_w[u] = 1'b0;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < div; c++) begin
        cyc = b * div + c;
        if (inject && cyc == 5) begin
          valid_w[u] = 1'b1;
          data_w     = ~data;
        end else begin
          valid_w[u] = 1'b0;
        end
        chk($sformatf("u%0d_so_c%0d", u, cyc), 32'(so_w[u]), 32'(seq[b]));
        chk($sformatf("u%0d_ready_c%0d", u, cyc), 32'(ready_w[u]), 32'(cyc == n * div - 1));
        chk($sformatf("u%0d_busy_c%0d", u, cyc), 32'(busy_w[u]), 32'd1);
        chk($sformatf("u%0d_done_c%0d", u, cyc), 32'(done_w[u]), 32'd0);
        step();
      end
    end
    valid_w[u] = 1'b0;
    chk($sformatf("u%0d_done_end", u), 32'(done_w[u]), 32'd1);
    chk($sformatf("u%0d_busy_end", u), 32'(busy_w[u]), 32'd0);
    chk($sformatf("u%0d_so_end", u), 32'(so_w[u]), 32'd1);
    chk($sformatf("u%0d_ready_end", u), 32'(ready_w[u]), 32'd1);
    step();
    chk($sformatf("u%0d_done_after", u), 32'(done_w[u]), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_w = '0;
    data_w  = '0;
    step();
    step();
    chk("rst_so", 32'(so_w), 32'h7);
    chk("rst_busy", 32'(busy_w), 32'h0);
    chk("rst_done", 32'(done_w), 32'h0);
    chk("rst_state0", 32'(st0_w), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(ready_w), 32'h7);

    // Idle with in_valid low: nothing moves.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_so", 32'(so_w), 32'h7);
      chk("idle_done", 32'(done_w), 32'h0);
      chk("idle_busy", 32'(busy_w), 32'h0);
    end

    // LSB first 0xA5 -> 1,0,1,0,0,1,0,1
    run_frame(0, 16'h00A5, 8, 1, 8'hA5, 1'b0);
    // MSB first 0xA5 -> bit7..bit0 = 1,0,1,0,0,1,0,1
    run_frame(1, 16'h00A5, 8, 1, 8'hA5, 1'b0);
    // MSB first 0x01 -> seven 0s then a 1
    run_frame(1, 16'h0080, 8, 1, 8'h01, 1'b0);
    // Framed: start 0, 0x3C LSB first, stop 1; a competing word mid-frame is ignored.
    run_frame(2, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 4, 8'h3C, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("frm_no_extra_done", 32'(done_w[2]), 32'd0);
      chk("frm_idle_so", 32'(so_w[2]), 32'd1);
    end

    // Back-to-back 0xFF then 0x00 on the LSB unit.
    data_w     = 8'hFF;
    valid_w[0] = 1'b1;
    step();
    data_w = 8'h00;
    for (int c = 0; c < 8; c++) begin
      chk("b2b_so_ff", 32'(so_w[0]), 32'd1);
      chk("b2b_done_first", 32'(done_w[0]), 32'd0);
      chk("b2b_ready_first", 32'(ready_w[0]), 32'(c == 7));
      if (c < 7) step();
    end
    step();
    valid_w[0] = 1'b0;
    chk("b2b_done_8", 32'(done_w[0]), 32'd1);
    chk("b2b_busy_8", 32'(busy_w[0]), 32'd1);
    for (int c = 8; c < 16; c++) begin
      chk("b2b_so_00", 32'(so_w[0]), 32'd0);
      if (c > 8) chk("b2b_done_second", 32'(done_w[0]), 32'd0);
      step();
    end
    chk("b2b_done_16", 32'(done_w[0]), 32'd1);
    chk("b2b_busy_16", 32'(busy_w[0]), 32'd0);
    chk("b2b_so_16", 32'(so_w[0]), 32'd1);
    step();

    // Reset mid-frame at bit 3 of 0xA5.
    data_w     = 8'hA5;
    valid_w[0] = 1'b1;
    step();
    valid_w[0] = 1'b0;
    step();
    step();
    step();
    chk("mid_so_bit3", 32'(so_w[0]), 32'd0);
    chk("mid_busy_bit3", 32'(busy_w[0]), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_so", 32'(so_w[0]), 32'd1);
    chk("mid_rst_busy", 32'(busy_w[0]), 32'd0);
    chk("mid_rst_done", 32'(done_w[0]), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("mid_rst_hold_done", 32'(done_w[0]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("mid_rel_ready", 32'(ready_w[0]), 32'd1);
    chk("mid_rel_done", 32'(done_w[0]), 32'd0);
    run_frame(0, 16'h000F, 8, 1, 8'h0F, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
